// File: rtl/multicycle_controller_pkg.sv
// Types and encodings shared by the multi-cycle RV32I controller and its ALU decoder.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, JAL, BEQ
`ifdef CTRL_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } mc_state_e;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
    } mc_control_signals_t;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields, memory handshake and control bundle between controller and datapath.
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic [6:0]          op;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    mc_control_signals_t ctrl;
    logic                instr_done;
    logic                bus_err;
    logic                trap;

    modport master (
        input  op, funct3, funct7, zero, mem_ready,
        output mem_req, ctrl, instr_done, bus_err, trap
    );

    modport slave (
        output op, funct3, funct7, zero, mem_ready,
        input  mem_req, ctrl, instr_done, bus_err, trap
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct fields to the ALU operation select.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic       op_b5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_b5_i,
    input  logic [1:0] alu_op_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            default: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (op_b5_i & funct7_b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with req/ready memory handshake and bus timeout.
// Define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);

    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    mc_state_e           state_q, state_d;
    logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
    mc_control_signals_t ctrl_raw, ctrl_out;
    logic                mem_req_raw, done_raw, branch, pc_update, timeout;
    logic [1:0]          alu_op;
    logic [2:0]          alu_control;
    logic                unused_funct7;

    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    // A stalled access aborts once it has waited TIMEOUT cycles; a ready in that cycle wins.
    assign timeout = (TIMEOUT != 0) && mem_req_raw && !bus.mem_ready && (wait_cnt_q == TO_VAL);

    always_comb begin
        state_d     = state_q;
        ctrl_raw    = '0;
        mem_req_raw = 1'b0;
        done_raw    = 1'b0;
        branch      = 1'b0;
        pc_update   = 1'b0;
        ctrl_raw.imm_src = imm_src_of(bus.op);
        case (state_q)
            FETCH: begin
                mem_req_raw         = 1'b1;
                ctrl_raw.alu_src_b  = SRCB_FOUR;
                ctrl_raw.result_src = RES_ALURES;
                if (bus.mem_ready) begin
                    ctrl_raw.ir_write = 1'b1;
                    pc_update         = 1'b1;
                    state_d           = DECODE;
                end
            end
            DECODE: begin
                ctrl_raw.alu_src_a = SRCA_OLDPC;
                ctrl_raw.alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        state_d  = FETCH;
                        done_raw = 1'b1;
`endif
                    end
                endcase
            end
            MEMADR: begin
                ctrl_raw.alu_src_a = SRCA_RD1;
                ctrl_raw.alu_src_b = SRCB_IMM;
                state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_raw         = 1'b1;
                ctrl_raw.adr_src    = 1'b1;
                ctrl_raw.result_src = RES_ALUOUT;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ctrl_raw.result_src = RES_DATA;
                ctrl_raw.reg_write  = 1'b1;
                done_raw            = 1'b1;
                state_d             = FETCH;
            end
            MEMWRITE: begin
                mem_req_raw        = 1'b1;
                ctrl_raw.adr_src   = 1'b1;
                ctrl_raw.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    done_raw = 1'b1;
                    state_d  = FETCH;
                end
            end
            EXECUTER: begin
                ctrl_raw.alu_src_a = SRCA_RD1;
                ctrl_raw.alu_src_b = SRCB_RD2;
                state_d            = ALUWB;
            end
            EXECUTEI: begin
                ctrl_raw.alu_src_a = SRCA_RD1;
                ctrl_raw.alu_src_b = SRCB_IMM;
                state_d            = ALUWB;
            end
            ALUWB: begin
                ctrl_raw.result_src = RES_ALUOUT;
                ctrl_raw.reg_write  = 1'b1;
                done_raw            = 1'b1;
                state_d             = FETCH;
            end
            JAL: begin
                ctrl_raw.alu_src_a  = SRCA_OLDPC;
                ctrl_raw.alu_src_b  = SRCB_FOUR;
                ctrl_raw.result_src = RES_ALUOUT;
                pc_update           = 1'b1;
                state_d             = ALUWB;
            end
            BEQ: begin
                ctrl_raw.alu_src_a  = SRCA_RD1;
                ctrl_raw.alu_src_b  = SRCB_RD2;
                ctrl_raw.result_src = RES_ALUOUT;
                branch              = 1'b1;
                done_raw            = 1'b1;
                state_d             = FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP: state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase
        if (timeout) begin
            state_d            = FETCH;
            ctrl_raw.ir_write  = 1'b0;
            ctrl_raw.reg_write = 1'b0;
            pc_update          = 1'b0;
            done_raw           = 1'b0;
        end
    end

    always_comb begin
        case (state_q)
            EXECUTER, EXECUTEI: alu_op = ALUOP_FUNCT;
            BEQ:                alu_op = ALUOP_SUB;
            default:            alu_op = ALUOP_ADD;
        endcase
    end

    multicycle_controller_alu_decoder u_alu_dec (
        .op_b5_i       (bus.op[5]),
        .funct3_i      (bus.funct3),
        .funct7_b5_i   (bus.funct7[5]),
        .alu_op_i      (alu_op),
        .alu_control_o (alu_control)
    );

    always_comb begin
        if (bus.mem_ready || timeout || (state_d != state_q)) begin
            wait_cnt_d = '0;
        end else if (mem_req_raw) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Reset gates every output combinationally so an in-flight access drops immediately.
    always_comb begin
        ctrl_out             = ctrl_raw;
        ctrl_out.alu_control = alu_control;
        ctrl_out.pc_write    = (branch & bus.zero) | pc_update;
        if (rst) ctrl_out = '0;
    end

    assign bus.ctrl       = ctrl_out;
    assign bus.mem_req    = mem_req_raw & ~rst;
    assign bus.instr_done = done_raw & ~rst;
    assign bus.bus_err    = timeout & ~rst;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.trap       = (state_q == TRAP) & ~rst;
`else
    assign bus.trap       = 1'b0;
`endif

endmodule
